// File: rtl/mem_stage.sv
// Memory-access pipeline stage between EX and WB.
// Holds one instruction and waits for the data-SRAM response of a load or store.
// Aligns and sign/zero-extends load data, and drives the WB bus plus an ID bypass.
// Ports:
//   clk, resetn                  clock, asynchronous active-low reset
//   EX_Valid, EX_to_ME_Bus[74:0] instruction offered by EX
//   ME_Unit_Ready                combinational allowin back to EX
//   data_sram_data_ok/_rdata     SRAM response pulse and load data
//   ME_Valid, WB_Unit_Ready      handshake towards WB
//   ME_to_WB_Bus[69:0]           {pc, gr_we, dest, final_result}
//   ME_to_ID_Bypass[38:0]        {fwd_we, dest, final_result, ld_pending}
module mem_stage (
  input  logic        clk,
  input  logic        resetn,
  input  logic        EX_Valid,
  output logic        ME_Unit_Ready,
  input  logic [74:0] EX_to_ME_Bus,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic        ME_Valid,
  input  logic        WB_Unit_Ready,
  output logic [69:0] ME_to_WB_Bus,
  output logic [38:0] ME_to_ID_Bypass
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            gr_we;
    logic [4:0]      dest;
    logic [XLEN-1:0] alu_result;
    logic            is_load;
    logic            is_mem;
    logic [2:0]      load_op;
  } ex_bus_t;

  state_t          state_q, state_d;
  ex_bus_t         stage_q;
  ex_bus_t         ex_in;
  logic [XLEN-1:0] rdata_buf;

  logic            accept;
  logic            handoff;
  logic            resp;
  logic [XLEN-1:0] raw_data;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] final_result;

  assign ex_in = ex_bus_t'(EX_to_ME_Bus);

  // Response only counts while waiting on our own access.
  assign resp          = (state_q == S_WAIT) & data_sram_data_ok;
  assign ME_Valid      = (state_q == S_DONE) | resp;
  assign handoff       = ME_Valid & WB_Unit_Ready;
  assign ME_Unit_Ready = (state_q == S_IDLE) | handoff;
  assign accept        = EX_Valid & ME_Unit_Ready;

  // Next state: later assignments take priority (accept > handoff > response).
  always_comb begin
    state_d = state_q;
    if (resp)    state_d = S_DONE;
    if (handoff) state_d = S_IDLE;
    if (accept)  state_d = ex_in.is_mem ? S_WAIT : S_DONE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      stage_q   <= '0;
      rdata_buf <= '0;
    end else begin
      state_q <= state_d;
      if (accept) stage_q   <= ex_in;
      if (resp)   rdata_buf <= data_sram_rdata;
    end
  end

  // Live SRAM data on the response cycle, captured copy afterwards.
  assign raw_data = (state_q == S_WAIT) ? data_sram_rdata : rdata_buf;

  // Byte/half selection by address offset; half ignores a[0].
  always_comb begin
    byte_sel = raw_data[7:0];
    case (stage_q.alu_result[1:0])
      2'd1:    byte_sel = raw_data[15:8];
      2'd2:    byte_sel = raw_data[23:16];
      2'd3:    byte_sel = raw_data[31:24];
      default: byte_sel = raw_data[7:0];
    endcase
    half_sel = stage_q.alu_result[1] ? raw_data[31:16] : raw_data[15:0];
  end

  always_comb begin
    load_data = raw_data;
    case (stage_q.load_op)
      3'b001:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b010:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_data = {24'd0, byte_sel};
      3'b110:  load_data = {16'd0, half_sel};
      default: load_data = raw_data;
    endcase
  end

  assign final_result = stage_q.is_load ? load_data : stage_q.alu_result;

  assign ME_to_WB_Bus = {stage_q.pc, stage_q.gr_we, stage_q.dest, final_result};

  assign ME_to_ID_Bypass = {
    (state_q != S_IDLE) & stage_q.gr_we & (stage_q.dest != 5'd0),
    stage_q.dest,
    final_result,
    (state_q == S_WAIT) & stage_q.is_load & ~data_sram_data_ok
  };

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: non-mem ops, load alignment, stores,
// WB backpressure, back-to-back streaming and reset during a pending access.
module tb_mem_stage;

  logic        clk;
  logic        resetn;
  logic        EX_Valid;
  logic        ME_Unit_Ready;
  logic [74:0] EX_to_ME_Bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        ME_Valid;
  logic        WB_Unit_Ready;
  logic [69:0] ME_to_WB_Bus;
  logic [38:0] ME_to_ID_Bypass;

  int n_total;
  int n_bad;
  int n_handoff;

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .EX_Valid          (EX_Valid),
    .ME_Unit_Ready     (ME_Unit_Ready),
    .EX_to_ME_Bus      (EX_to_ME_Bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ME_Valid          (ME_Valid),
    .WB_Unit_Ready     (WB_Unit_Ready),
    .ME_to_WB_Bus      (ME_to_WB_Bus),
    .ME_to_ID_Bypass   (ME_to_ID_Bypass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [74:0] got, input logic [74:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [74:0] mk_ex(input logic [31:0] pc, input logic we,
                                        input logic [4:0] dest, input logic [31:0] alu,
                                        input logic is_load, input logic is_mem,
                                        input logic [2:0] op);
    return {pc, we, dest, alu, is_load, is_mem, op};
  endfunction

  function automatic logic [69:0] mk_wb(input logic [31:0] pc, input logic we,
                                        input logic [4:0] dest, input logic [31:0] res);
    return {pc, we, dest, res};
  endfunction

  // Inputs change 1 time unit after the rising edge; checks happen 2 units later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Accept a mem op, return data_ok on the next cycle with WB ready.
  task automatic do_mem(input string tag, input logic is_load, input logic [2:0] op,
                        input logic [31:0] alu, input logic [31:0] rdata,
                        input logic [31:0] exp_res);
    EX_Valid     = 1'b1;
    EX_to_ME_Bus = mk_ex(32'h1c000100, 1'b1, 5'd9, alu, is_load, 1'b1, op);
    step();
    EX_Valid = 1'b0;
    settle();
    check_val({tag, "_wait_valid"}, 75'(ME_Valid), 75'(1'b0));
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = rdata;
    settle();
    check_val({tag, "_valid"}, 75'(ME_Valid), 75'(1'b1));
    check_val({tag, "_bus"}, 75'(ME_to_WB_Bus), 75'(mk_wb(32'h1c000100, 1'b1, 5'd9, exp_res)));
    step();
    data_sram_data_ok = 1'b0;
    settle();
    check_val({tag, "_idle"}, 75'(ME_Unit_Ready), 75'(1'b1));
  endtask

  logic [31:0] stream_alu [4];

  initial begin
    n_total = 0;
    n_bad = 0;
    n_handoff = 0;
    resetn = 1'b0;
    EX_Valid = 1'b0;
    EX_to_ME_Bus = '0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata = '0;
    WB_Unit_Ready = 1'b1;
    stream_alu[0] = 32'h00000011;
    stream_alu[1] = 32'h00000022;
    stream_alu[2] = 32'h00000033;
    stream_alu[3] = 32'h00000044;

    // Reset state
    #3;
    check_val("rst_valid", 75'(ME_Valid), 75'(1'b0));
    check_val("rst_ready", 75'(ME_Unit_Ready), 75'(1'b1));
    check_val("rst_wb_bus", 75'(ME_to_WB_Bus), 75'd0);
    check_val("rst_bypass", 75'(ME_to_ID_Bypass), 75'd0);
    step();
    resetn = 1'b1;
    step();

    // Non-mem op: valid the cycle after accept
    EX_Valid     = 1'b1;
    EX_to_ME_Bus = mk_ex(32'h1c000000, 1'b1, 5'd5, 32'h00001234, 1'b0, 1'b0, 3'b000);
    settle();
    check_val("nm_accept_ready", 75'(ME_Unit_Ready), 75'(1'b1));
    check_val("nm_accept_valid", 75'(ME_Valid), 75'(1'b0));
    step();
    EX_Valid = 1'b0;
    settle();
    check_val("nm_valid", 75'(ME_Valid), 75'(1'b1));
    check_val("nm_bus", 75'(ME_to_WB_Bus), 75'(mk_wb(32'h1c000000, 1'b1, 5'd5, 32'h00001234)));
    check_val("nm_bypass", 75'(ME_to_ID_Bypass), 75'({1'b1, 5'd5, 32'h00001234, 1'b0}));
    step();
    settle();
    check_val("nm_after_valid", 75'(ME_Valid), 75'(1'b0));
    check_val("nm_after_ready", 75'(ME_Unit_Ready), 75'(1'b1));
    check_val("nm_after_fwd", 75'(ME_to_ID_Bypass[38]), 75'(1'b0));

    // ld.b a=3 with data_ok two cycles after accept
    EX_Valid     = 1'b1;
    EX_to_ME_Bus = mk_ex(32'h1c000004, 1'b1, 5'd6, 32'h00001003, 1'b1, 1'b1, 3'b001);
    step();
    EX_Valid = 1'b0;
    settle();
    check_val("ldb_c1_valid", 75'(ME_Valid), 75'(1'b0));
    check_val("ldb_c1_pending", 75'(ME_to_ID_Bypass[0]), 75'(1'b1));
    check_val("ldb_c1_fwd", 75'(ME_to_ID_Bypass[38]), 75'(1'b1));
    check_val("ldb_c1_ready", 75'(ME_Unit_Ready), 75'(1'b0));
    step();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h80FF7F01;
    settle();
    check_val("ldb_c2_valid", 75'(ME_Valid), 75'(1'b1));
    check_val("ldb_c2_pending", 75'(ME_to_ID_Bypass[0]), 75'(1'b0));
    check_val("ldb_c2_bus", 75'(ME_to_WB_Bus), 75'(mk_wb(32'h1c000004, 1'b1, 5'd6, 32'hFFFFFF80)));
    check_val("ldb_c2_ready", 75'(ME_Unit_Ready), 75'(1'b1));
    step();
    data_sram_data_ok = 1'b0;
    settle();
    check_val("ldb_after_valid", 75'(ME_Valid), 75'(1'b0));

    // Alignment / extension table and a store
    do_mem("ldhu_a2", 1'b1, 3'b110, 32'h00002002, 32'h8001ABCD, 32'h00008001);
    do_mem("ldh_a0",  1'b1, 3'b010, 32'h00002000, 32'h8001ABCD, 32'hFFFFABCD);
    do_mem("ldh_a3",  1'b1, 3'b010, 32'h00002003, 32'h8001ABCD, 32'hFFFF8001);
    do_mem("ldw",     1'b1, 3'b000, 32'h00002003, 32'h8001ABCD, 32'h8001ABCD);
    do_mem("ldbu_a1", 1'b1, 3'b101, 32'h00002001, 32'h8001ABCD, 32'h000000AB);
    do_mem("ldb_a1",  1'b1, 3'b001, 32'h00002001, 32'h8001ABCD, 32'hFFFFFFAB);
    do_mem("ldb_a0",  1'b1, 3'b001, 32'h00002000, 32'h80FF7F01, 32'h00000001);
    do_mem("ld_op3",  1'b1, 3'b011, 32'h00002001, 32'h8001ABCD, 32'h8001ABCD);
    do_mem("store",   1'b0, 3'b000, 32'h00003008, 32'hDEADBEEF, 32'h00003008);

    // Backpressure: response while WB stalls, outputs held
    EX_Valid     = 1'b1;
    EX_to_ME_Bus = mk_ex(32'h1c000200, 1'b1, 5'd7, 32'h00004002, 1'b1, 1'b1, 3'b010);
    step();
    EX_Valid          = 1'b0;
    WB_Unit_Ready     = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hF00D1234;
    settle();
    check_val("bp_resp_valid", 75'(ME_Valid), 75'(1'b1));
    check_val("bp_resp_bus", 75'(ME_to_WB_Bus), 75'(mk_wb(32'h1c000200, 1'b1, 5'd7, 32'hFFFFF00D)));
    for (int i = 0; i < 2; i++) begin
      step();
      data_sram_data_ok = (i == 1);
      data_sram_rdata   = 32'hDEADBEEF;
      settle();
      check_val("bp_hold_valid", 75'(ME_Valid), 75'(1'b1));
      check_val("bp_hold_ready", 75'(ME_Unit_Ready), 75'(1'b0));
      check_val("bp_hold_bus", 75'(ME_to_WB_Bus), 75'(mk_wb(32'h1c000200, 1'b1, 5'd7, 32'hFFFFF00D)));
    end
    step();
    data_sram_data_ok = 1'b0;
    WB_Unit_Ready     = 1'b1;
    settle();
    check_val("bp_release_valid", 75'(ME_Valid), 75'(1'b1));
    check_val("bp_release_ready", 75'(ME_Unit_Ready), 75'(1'b1));
    check_val("bp_release_res", 75'(ME_to_WB_Bus[31:0]), 75'(32'hFFFFF00D));
    step();
    settle();
    check_val("bp_after_valid", 75'(ME_Valid), 75'(1'b0));

    // Stream four non-mem ops back to back
    EX_Valid     = 1'b1;
    EX_to_ME_Bus = mk_ex(32'h1c000300, 1'b1, 5'd3, stream_alu[0], 1'b0, 1'b0, 3'b000);
    step();
    for (int k = 0; k < 4; k++) begin
      if (k < 3)
        EX_to_ME_Bus = mk_ex(32'h1c000300, 1'b1, 5'd3, stream_alu[k+1], 1'b0, 1'b0, 3'b000);
      else
        EX_Valid = 1'b0;
      settle();
      if (ME_Valid && WB_Unit_Ready) n_handoff++;
      check_val("stream_res", 75'(ME_to_WB_Bus[31:0]), 75'(stream_alu[k]));
      check_val("stream_ready", 75'(ME_Unit_Ready), 75'(1'b1));
      step();
    end
    settle();
    check_val("stream_handoffs", 75'(n_handoff), 75'(4));
    check_val("stream_end_valid", 75'(ME_Valid), 75'(1'b0));

    // Reset while waiting on a load, then a stray response
    EX_Valid     = 1'b1;
    EX_to_ME_Bus = mk_ex(32'h1c000400, 1'b1, 5'd8, 32'h00005000, 1'b1, 1'b1, 3'b000);
    step();
    EX_Valid = 1'b0;
    settle();
    check_val("rw_pending", 75'(ME_to_ID_Bypass[0]), 75'(1'b1));
    resetn = 1'b0;
    #1;
    check_val("rw_rst_valid", 75'(ME_Valid), 75'(1'b0));
    check_val("rw_rst_ready", 75'(ME_Unit_Ready), 75'(1'b1));
    check_val("rw_rst_bus", 75'(ME_to_WB_Bus), 75'd0);
    check_val("rw_rst_bypass", 75'(ME_to_ID_Bypass), 75'd0);
    #1;
    resetn = 1'b1;
    step();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h12345678;
    settle();
    check_val("rw_stray_valid", 75'(ME_Valid), 75'(1'b0));
    step();
    data_sram_data_ok = 1'b0;
    settle();
    check_val("rw_after_valid", 75'(ME_Valid), 75'(1'b0));
    check_val("rw_after_bus", 75'(ME_to_WB_Bus), 75'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
